mem_port_arbiter: RTL and testbench

- Shares the single system RAM port (address/write-enable/write-data/read-data) between two requesters.
- Requester 0 is the CPU load/store/fetch path. Requester 1 is an auxiliary master, such as a sprite/glyph copier or a game-input logger.
- Sits between the CPU address mux and the RAM port used in RAM-override builds. Provides round-robin arbitration, bounded bursts for the auxiliary master and tagged read-data return.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_rr2.sv | 37 +++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester RAM port arbiter.
//   - arb_state_t : who owned the RAM port in the previous cycle
//   - REQ_CPU / REQ_AUX : requester IDs used for last_winner and the read tag
//   - DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default RAM geometry
package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no grant last cycle
    OWN0 = 2'd1,  // CPU granted last cycle
    OWN1 = 2'd2   // auxiliary master granted last cycle
  } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker with a lock override for requester 1.
// Purely combinational; at most one of gnt0/gnt1 is high.
// Ports:
//   req0, req1   : active requests
//   last_winner  : ID of the requester granted most recently (REQ_CPU/REQ_AUX)
//   lock_ok      : requester 1 may keep the port (locked burst not yet exhausted)
//   gnt0, gnt1   : one-hot (or zero) grant
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  input  logic lock_ok,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && !req1) begin
      gnt0 = 1'b1;
    end else if (req1 && !req0) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      if (lock_ok) begin
        gnt1 = 1'b1;
      end else if (last_winner == REQ_AUX) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between the CPU (requester 0) and an
// auxiliary master (requester 1) with round-robin arbitration, bounded
// locked bursts for requester 1 and tagged one-cycle read return.
//
// Handshake: a requester raises reqX with weX/addrX/wdataX and holds them
// stable; the access is issued in the cycle gntX is high (gnt is
// combinational, ram_* carry the winner's fields in that same cycle). A
// read issued in cycle N returns with rvalidX = 1 and rdataX = ram_rdata in
// cycle N+1 only; there is no back-pressure on the return. Dropping reqX
// before gntX abandons the access.
//
// Ports:
//   clk, reset                      : clock, async active-high reset
//   req0/we0/addr0/wdata0           : CPU request
//   gnt0/rvalid0/rdata0             : CPU grant and read return
//   req1/we1/addr1/wdata1/lock1     : auxiliary request (+ burst lock)
//   gnt1/rvalid1/rdata1             : auxiliary grant and read return
//   ram_we/ram_addr/ram_wdata       : RAM command (addr/wdata hold when idle)
//   ram_rdata                       : RAM read data, one cycle after address
//   busy                            : access issued now or read return pending
//   state_dbg, burst_cnt_dbg        : registered arbiter state for observation
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MAX_BURST   = 8,
  parameter int BURST_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   we0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  wdata0,
  output logic                   gnt0,
  output logic                   rvalid0,
  output logic [DATA_WIDTH-1:0]  rdata0,
  input  logic                   req1,
  input  logic                   we1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0]  wdata1,
  input  logic                   lock1,
  output logic                   gnt1,
  output logic                   rvalid1,
  output logic [DATA_WIDTH-1:0]  rdata1,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_wdata,
  input  logic [DATA_WIDTH-1:0]  ram_rdata,
  output logic                   busy,
  output arb_state_t             state_dbg,
  output logic [BURST_CNT_W-1:0] burst_cnt_dbg
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);

  arb_state_t             state_q, state_d;
  logic                   last_winner_q, last_winner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   rd_pend_q;   // read issued last cycle
  logic                   rd_tag_q;    // which requester that read belongs to
  logic [ADDR_WIDTH-1:0]  addr_hold_q;
  logic [DATA_WIDTH-1:0]  wdata_hold_q;
  logic [DATA_WIDTH-1:0]  rdata0_q, rdata1_q;
  logic                   lock_ok;
  logic                   pick0, pick1;
  logic                   any_gnt;

  // Requester 1 keeps the port only if it held it last cycle and the
  // locked burst has not yet used up its allowance.
  assign lock_ok = (state_q == OWN1) && lock1 && (burst_cnt_q < BURST_MAX);

  arb_rr2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_winner (last_winner_q),
    .lock_ok     (lock_ok),
    .gnt0        (pick0),
    .gnt1        (pick1)
  );

  // Grants are combinational, so they are gated by reset to reach their
  // reset value immediately rather than at the next edge.
  assign gnt0    = pick0 & ~reset;
  assign gnt1    = pick1 & ~reset;
  assign any_gnt = gnt0 | gnt1;

  // RAM command mux; addr/wdata keep the last issued values when idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_hold_q;
    ram_wdata = wdata_hold_q;
    if (gnt0) begin
      ram_we    = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (gnt1) begin
      ram_we    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end
  end

  // Next state, winner history and locked-burst counter.
  always_comb begin
    state_d       = IDLE;
    last_winner_d = last_winner_q;
    burst_cnt_d   = burst_cnt_q;
    if (gnt0) begin
      state_d       = OWN0;
      last_winner_d = REQ_CPU;
    end else if (gnt1) begin
      state_d       = OWN1;
      last_winner_d = REQ_AUX;
    end
    // The counter only measures how long the CPU has been kept waiting by
    // an unbroken run of requester-1 grants.
    if (gnt0 || !any_gnt || !req0 || state_q == IDLE) begin
      burst_cnt_d = '0;
    end else if (gnt1 && state_q == OWN1 && burst_cnt_q < BURST_MAX) begin
      burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_winner_q <= REQ_AUX;
      burst_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end

  // Command hold registers and the one-deep read return tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= REQ_CPU;
    end else begin
      if (any_gnt) begin
        addr_hold_q  <= ram_addr;
        wdata_hold_q <= ram_wdata;
      end
      rd_pend_q <= any_gnt & ~ram_we;
      rd_tag_q  <= gnt1 ? REQ_AUX : REQ_CPU;
    end
  end

  assign rvalid0 = rd_pend_q && (rd_tag_q == REQ_CPU);
  assign rvalid1 = rd_pend_q && (rd_tag_q == REQ_AUX);

  // Return data is presented straight from the RAM in the valid cycle and
  // captured so it stays put afterwards.
  assign rdata0 = rvalid0 ? ram_rdata : rdata0_q;
  assign rdata1 = rvalid1 ? ram_rdata : rdata1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= ram_rdata;
      if (rvalid1) rdata1_q <= ram_rdata;
    end
  end

  assign busy          = any_gnt | rd_pend_q;
  assign state_dbg     = state_q;
  assign burst_cnt_dbg = burst_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int MAXB = 4;
  localparam int CW   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0, lock1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
  logic [DW-1:0] rdata0, rdata1, ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;
  arb_state_t    state_dbg;
  logic [CW-1:0] burst_cnt_dbg;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB), .BURST_CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy),
    .state_dbg(state_dbg), .burst_cnt_dbg(burst_cnt_dbg)
  );

  // ---------------- environment RAM (synchronous) ----------------
  logic [DW-1:0] ram     [65536];
  logic [DW-1:0] ref_mem [65536];

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 3) ^ 16'h5A5A;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    ram[16'h0010]     = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
  end

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owned the port last cycle (-1 none), who won
  // last, how many consecutive aux grants have kept a waiting CPU out,
  // pending read returns, and the values each requester last received.
  int            m_prev  = -1;
  int            m_last  = 1;
  int            m_burst = 0;
  logic [DW-1:0] exp_q[$];
  int            who_q[$];
  logic [DW-1:0] m_rdata [2];
  logic [AW-1:0] m_addr_hold = '0;
  logic [DW-1:0] m_wdata_hold = '0;

  always @(negedge clk) begin
    int            e;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          rv_has;
    int            rv_who;
    logic [DW-1:0] rv_data;
    logic          x_rv0, x_rv1;
    logic [DW-1:0] x_rd0, x_rd1;
    arb_state_t    x_st;
    if (reset) begin
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_busy", busy, 0);
      m_prev = -1; m_last = 1; m_burst = 0;
      exp_q.delete(); who_q.delete();
      m_rdata[0] = '0; m_rdata[1] = '0;
      m_addr_hold = '0; m_wdata_hold = '0;
    end else begin
      // who should win this cycle
      e = -1;
      if (req0 && !req1) e = 0;
      else if (req1 && !req0) e = 1;
      else if (req0 && req1) begin
        if (m_prev == 1 && lock1 && m_burst < MAXB) e = 1;
        else e = 1 - m_last;
      end
      e_we    = (e == 0) ? we0 : (e == 1) ? we1 : 1'b0;
      e_addr  = (e == 0) ? addr0 : (e == 1) ? addr1 : m_addr_hold;
      e_wdata = (e == 0) ? wdata0 : (e == 1) ? wdata1 : m_wdata_hold;

      rv_has  = (exp_q.size() > 0);
      rv_who  = rv_has ? who_q[0] : 0;
      rv_data = rv_has ? exp_q[0] : '0;
      x_rv0   = rv_has && rv_who == 0;
      x_rv1   = rv_has && rv_who == 1;
      x_rd0   = x_rv0 ? rv_data : m_rdata[0];
      x_rd1   = x_rv1 ? rv_data : m_rdata[1];
      x_st    = (m_prev < 0) ? IDLE : (m_prev == 0) ? OWN0 : OWN1;

      chk("gnt0", gnt0, e == 0);
      chk("gnt1", gnt1, e == 1);
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wdata);
      chk("rvalid0", rvalid0, x_rv0);
      chk("rvalid1", rvalid1, x_rv1);
      chk("rdata0", rdata0, x_rd0);
      chk("rdata1", rdata1, x_rd1);
      chk("busy", busy, (e >= 0) || rv_has);
      chk("state", state_dbg, x_st);
      chk("burst_cnt", burst_cnt_dbg, m_burst);

      // advance the model
      if (rv_has) begin
        m_rdata[rv_who] = rv_data;
        void'(exp_q.pop_front());
        void'(who_q.pop_front());
      end
      if (e >= 0) begin
        if (e_we) ref_mem[e_addr] = e_wdata;
        else begin
          exp_q.push_back(ref_mem[e_addr]);
          who_q.push_back(e);
        end
        m_addr_hold  = e_addr;
        m_wdata_hold = e_wdata;
        m_last = e;
      end
      if (e == 1 && m_prev == 1 && req0) m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
      else m_burst = 0;
      m_prev = e;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; clear_inputs();
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq [4];
    int n1;
    logic saw0;
    logic g0, g1;

    clear_inputs();
    do_reset();

    // CPU read of 0x0010 holding 0xBEEF
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    @(negedge clk);
    chk("t1_gnt0", gnt0, 1);
    chk("t1_addr", ram_addr, 16'h0010);
    @(posedge clk); #1;
    req0 = 0;
    @(negedge clk);
    chk("t1_rvalid0", rvalid0, 1);
    chk("t1_rdata0", rdata0, 16'hBEEF);
    chk("t1_rvalid1", rvalid1, 0);
    @(negedge clk);
    chk("t1_rvalid0_off", rvalid0, 0);
    chk("t1_rdata0_hold", rdata0, 16'hBEEF);

    // both requesting, no lock: 0,1,0,1
    do_reset();
    @(posedge clk); #1;
    req0 = 1; addr0 = 16'h0020; req1 = 1; addr1 = 16'h0021;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq[i] = gnt1 ? 1 : (gnt0 ? 0 : 2);
    end
    chk("t2_g0", seq[0], 0);
    chk("t2_g1", seq[1], 1);
    chk("t2_g2", seq[2], 0);
    chk("t2_g3", seq[3], 1);
    @(posedge clk); #1;
    clear_inputs();

    // locked burst bounded by MAX_BURST
    do_reset();
    @(posedge clk); #1;
    req1 = 1; lock1 = 1; we1 = 0; addr1 = 16'h0040;
    @(negedge clk);
    chk("t3_first_gnt1", gnt1, 1);
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 16'h0041;
    n1 = 0; saw0 = 0;
    for (int i = 0; i < 20 && !saw0; i++) begin
      @(negedge clk);
      if (gnt0) saw0 = 1;
      else if (gnt1) n1++;
    end
    chk("t3_cpu_granted", saw0, 1);
    chk("t3_burst_len", n1, MAXB);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("t3_cnt_clear", burst_cnt_dbg, 0);
    chk("t3_state_own0", state_dbg, OWN0);

    // aux write then CPU read of the same address
    do_reset();
    @(posedge clk); #1;
    req1 = 1; we1 = 1; addr1 = 16'h0200; wdata1 = 16'h1234;
    @(negedge clk);
    chk("t4_gnt1", gnt1, 1);
    chk("t4_we_n", ram_we, 1);
    chk("t4_wdata", ram_wdata, 16'h1234);
    @(posedge clk); #1;
    req1 = 0; we1 = 0; req0 = 1; we0 = 0; addr0 = 16'h0200;
    @(negedge clk);
    chk("t4_gnt0", gnt0, 1);
    chk("t4_we_n1", ram_we, 0);
    @(posedge clk); #1;
    req0 = 0;
    @(negedge clk);
    chk("t4_rvalid0", rvalid0, 1);
    chk("t4_rdata0", rdata0, 16'h1234);
    chk("t4_we_n2", ram_we, 0);

    // reset right after an aux read grant
    do_reset();
    @(posedge clk); #1;
    req1 = 1; we1 = 0; addr1 = 16'h0033;
    @(negedge clk);
    chk("t5_gnt1", gnt1, 1);
    #3;
    reset = 1; req1 = 0;
    #1;
    chk("t5_async_gnt1", gnt1, 0);
    chk("t5_async_rvalid1", rvalid1, 0);
    chk("t5_async_addr", ram_addr, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_state", state_dbg, IDLE);
    repeat (2) begin
      @(negedge clk);
      chk("t5_rvalid1_in_rst", rvalid1, 0);
    end
    @(posedge clk); #1;
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_rvalid1_after", rvalid1, 0);
    end

    // activity then 10 idle cycles
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 16'h0005; wdata0 = 16'h7777;
    @(negedge clk);
    @(posedge clk); #1;
    clear_inputs();
    repeat (10) begin
      @(negedge clk);
      chk("t6_ram_we", ram_we, 0);
      chk("t6_gnt", {gnt0, gnt1}, 0);
      chk("t6_busy", busy, 0);
    end
    chk("t6_state", state_dbg, IDLE);
    chk("t6_addr_hold", ram_addr, 16'h0005);

    // randomized traffic with the model checking every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = gnt0; g1 = gnt1;
      @(posedge clk); #1;
      if (!req0 || g0) begin
        req0 = ($urandom_range(0, 99) < 60);
        we0 = $urandom_range(0, 1);
        addr0 = AW'($urandom_range(0, 7));
        wdata0 = DW'($urandom);
      end else if ($urandom_range(0, 99) < 3) begin
        req0 = 0;
      end
      if (!req1 || g1) begin
        req1 = ($urandom_range(0, 99) < 70);
        we1 = $urandom_range(0, 1);
        addr1 = AW'($urandom_range(0, 7));
        wdata1 = DW'($urandom);
      end else if ($urandom_range(0, 99) < 3) begin
        req1 = 0;
      end
      lock1 = ($urandom_range(0, 99) < 60);
      if (c == 1500) begin
        reset = 1; clear_inputs();
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        reset = 0;
      end
    end

    @(posedge clk); #1;
    clear_inputs();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
